// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: default
// geometry constants and the controller state encoding.
package systolic_pkg;

  localparam int N_DEF  = 4;   // array dimension
  localparam int DW_DEF = 8;   // operand width
  localparam int CW_DEF = 32;  // accumulator width
  localparam int KW_DEF = 16;  // reduction-length count width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Job/operand/result bundle of the systolic engine. The master side starts
// jobs, streams A columns / B rows and consumes C rows; the slave side is
// the engine itself.
interface systolic_matmul_engine_if
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int KW = KW_DEF
) ();

  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            a_valid;
  logic            a_ready;
  logic [N*DW-1:0] a_data;
  logic [N*DW-1:0] b_data;
  logic            busy;
  logic            c_valid;
  logic            c_ready;
  logic [N*CW-1:0] c_row;
  logic [RW-1:0]   c_row_idx;
  logic            done;

  modport master (
    output start, k_len, signed_mode, a_valid, a_data, b_data, c_ready,
    input  a_ready, busy, c_valid, c_row, c_row_idx, done
  );

  modport slave (
    input  start, k_len, signed_mode, a_valid, a_data, b_data, c_ready,
    output a_ready, busy, c_valid, c_row, c_row_idx, done
  );

endinterface

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulate of the operands passing
// through it, plus one-cycle forwarding registers (a to the right, b down).
module systolic_pe #(
  parameter int DW = 8,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          signed_mode,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [CW-1:0] acc
);

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [CW-1:0] acc_q, acc_d;

  // Full 2*DW product widened to the accumulator width; the extension
  // follows the operand signedness so the accumulator wraps modulo 2^CW.
  function automatic logic [CW-1:0] widen_product(input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b,
                                                  input logic          sm);
    logic signed [2*DW-1:0] a_s, b_s, prod_s;
    logic        [2*DW-1:0] a_u, b_u, prod_u;
    a_s    = {{DW{a[DW-1]}}, a};
    b_s    = {{DW{b[DW-1]}}, b};
    prod_s = a_s * b_s;
    a_u    = {{DW{1'b0}}, a};
    b_u    = {{DW{1'b0}}, b};
    prod_u = a_u * b_u;
    if (sm) return {{(CW-2*DW){prod_s[2*DW-1]}}, prod_s};
    else    return {{(CW-2*DW){1'b0}}, prod_u};
  endfunction

  // Next-state: forward operands, accumulate or clear for a new job.
  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = clear ? '0 : acc_q + widen_product(a_in, b_in, signed_mode);
  end

  // Operand forwarding and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary N x N systolic matrix multiplier. Columns of A and rows
// of B stream in one beat per cycle, are skewed so that A[i][k] and B[k][j]
// meet in PE(i,j), and the finished C matrix is drained one row at a time.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int KW = KW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  systolic_matmul_engine_if.slave  bus
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(2 * N);
  // FLUSH covers the 2N-1 cycles the last beat needs to reach PE(N-1,N-1).
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_cnt_q, beat_cnt_d;
  logic          sm_q, sm_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          clear;
  logic          beat_fire;

  logic [DW-1:0] a_h [N][N];   // A operand entering PE(i,j)
  logic [DW-1:0] b_v [N][N];   // B operand entering PE(i,j)
  logic [CW-1:0] acc_w [N][N];
  logic [DW-1:0] a_unused [N]; // right edge of the array
  logic [DW-1:0] b_unused [N]; // bottom edge of the array
  logic [N*CW-1:0] c_row_mux;

  assign beat_fire = bus.a_valid && (state_q == LOAD);

  // Controller: job acceptance, beat counting, flush timing, row drain.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    sm_d        = sm_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear      = 1'b1;
          k_len_d    = bus.k_len;
          sm_d       = bus.signed_mode;
          beat_cnt_d = '0;
          row_d      = '0;
          state_d    = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.c_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      sm_q        <= 1'b0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      sm_q        <= sm_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  // Input skew: lane l passes through l+1 registers; cycles without an
  // accepted beat inject zeros so bubbles leave the sums untouched.
  for (genvar l = 0; l < N; l++) begin : g_skew
    logic [DW-1:0] a_dly_q [0:l];
    logic [DW-1:0] a_dly_d [0:l];
    logic [DW-1:0] b_dly_q [0:l];
    logic [DW-1:0] b_dly_d [0:l];

    // Shift the skew chains by one every cycle.
    always_comb begin
      a_dly_d[0] = beat_fire ? bus.a_data[l*DW +: DW] : '0;
      b_dly_d[0] = beat_fire ? bus.b_data[l*DW +: DW] : '0;
      for (int d = 1; d <= l; d++) begin
        a_dly_d[d] = a_dly_q[d-1];
        b_dly_d[d] = b_dly_q[d-1];
      end
    end

    // Skew chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= l; d++) begin
          a_dly_q[d] <= '0;
          b_dly_q[d] <= '0;
        end
      end else begin
        for (int d = 0; d <= l; d++) begin
          a_dly_q[d] <= a_dly_d[d];
          b_dly_q[d] <= b_dly_d[d];
        end
      end
    end

    assign a_h[l][0] = a_dly_q[l];
    assign b_v[0][l] = b_dly_q[l];
  end

  // PE grid: A travels along rows, B down columns.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_o, b_o;

      systolic_pe #(.DW(DW), .CW(CW)) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .signed_mode (sm_q),
        .a_in        (a_h[i][j]),
        .b_in        (b_v[i][j]),
        .a_out       (a_o),
        .b_out       (b_o),
        .acc         (acc_w[i][j])
      );

      if (j < N - 1) begin : g_a_fwd
        assign a_h[i][j+1] = a_o;
      end else begin : g_a_edge
        assign a_unused[i] = a_o;
      end

      if (i < N - 1) begin : g_b_fwd
        assign b_v[i+1][j] = b_o;
      end else begin : g_b_edge
        assign b_unused[j] = b_o;
      end
    end
  end

  // Present the selected accumulator row while draining, zeros otherwise.
  always_comb begin
    c_row_mux = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) c_row_mux[j*CW +: CW] = acc_w[row_q][j];
    end
  end

  assign bus.a_ready   = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.c_valid   = (state_q == DRAIN);
  assign bus.c_row     = c_row_mux;
  assign bus.c_row_idx = row_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Self-checking bench for systolic_matmul_engine: directed jobs with known
// results plus randomized jobs checked against a plain matrix-product model.
module tb_systolic_matmul_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int KW = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  systolic_matmul_engine_if #(.N(N), .DW(DW), .CW(CW), .KW(KW)) bus ();

  systolic_matmul_engine #(.N(N), .DW(DW), .CW(CW), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand matrices and observations of the most recent job.
  logic [DW-1:0] a_m [N][16];
  logic [DW-1:0] b_m [16][N];
  logic [CW-1:0] got [N][N];
  int   timeout_o, aready_cnt, aready_extra, last_acc_cyc, first_cv_cyc;
  int   order_bad, held_bad, done_early, stall_seen;
  logic done_now, cv_after, busy_after, done_next, busy_next;

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], operands read as signed or
  // unsigned, sum wrapping at 32 bits.
  function automatic logic [CW-1:0] ref_c(input int i, input int j,
                                          input int k, input bit sm);
    logic [CW-1:0] s;
    int av, bv;
    s = '0;
    for (int kk = 0; kk < k; kk++) begin
      av = sm ? int'($signed(a_m[i][kk])) : int'(a_m[i][kk]);
      bv = sm ? int'($signed(b_m[kk][j])) : int'(b_m[kk][j]);
      s  = s + 32'(av * bv);
    end
    return s;
  endfunction

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = a_m[i][k];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = b_m[k][j];
    return v;
  endfunction

  task automatic fill_ref_pattern();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        a_m[i][k] = DW'(i + k + 1);
        b_m[k][i] = DW'(k + i + 5);
      end
  endtask

  // Runs one job and records what was observed; vmode 0=continuous valid,
  // 1=valid every other cycle, 2=random valid. stall_at holds c_ready low
  // for three cycles when that row is first presented.
  task automatic do_job(input int k, input bit sm, input int vmode,
                        input int stall_at, input bit start_in_drain);
    int kb, guard, rows, ph;
    logic v, cr;
    logic [N*CW-1:0] snap;
    timeout_o = 0; aready_cnt = 0; aready_extra = 0; last_acc_cyc = -1;
    first_cv_cyc = -1; order_bad = 0; held_bad = 0; done_early = 0;
    stall_seen = 0; snap = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(k); bus.signed_mode = sm;
    bus.a_valid = 1'b0; bus.c_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.k_len = KW'($urandom); bus.signed_mode = ~sm;
    kb = 0; guard = 0; ph = 0;
    while (kb < k && guard < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (ph % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.a_valid = v;
      bus.a_data  = v ? pack_a(kb) : $urandom;
      bus.b_data  = v ? pack_b(kb) : $urandom;
      if (bus.a_ready) aready_cnt++;
      if (v && bus.a_ready) begin
        if (kb == k - 1) last_acc_cyc = cyc;
        kb++;
      end
      ph++; guard++;
      @(negedge clk);
    end
    if (guard >= 2000) timeout_o = 1;
    bus.a_valid = 1'b0; bus.a_data = $urandom; bus.b_data = $urandom;
    rows = 0; guard = 0;
    while (rows < N && guard < 2000) begin
      if (bus.a_ready) aready_extra++;
      if (bus.c_valid && first_cv_cyc < 0) first_cv_cyc = cyc;
      if (bus.done) done_early++;
      cr = 1'b1;
      bus.start = 1'b0;
      if (bus.c_valid) begin
        if (int'(bus.c_row_idx) == stall_at && stall_seen < 3) begin
          if (stall_seen == 0) snap = bus.c_row;
          else if (bus.c_row != snap) held_bad++;
          bus.start = start_in_drain && (stall_seen == 0);
          bus.k_len = KW'(3);
          cr = 1'b0;
          stall_seen++;
        end else begin
          if (stall_seen > 0 && int'(bus.c_row_idx) == stall_at && bus.c_row != snap)
            held_bad++;
          if (int'(bus.c_row_idx) != rows) order_bad++;
          for (int j = 0; j < N; j++)
            got[bus.c_row_idx][j] = bus.c_row[j*CW +: CW];
          rows++;
        end
      end
      bus.c_ready = cr;
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) timeout_o = 1;
    bus.start = 1'b0; bus.c_ready = 1'b1;
    done_now = bus.done; cv_after = bus.c_valid; busy_after = bus.busy;
    @(negedge clk);
    done_next = bus.done; busy_next = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.k_len = '0; bus.signed_mode = 1'b0;
    bus.a_valid = 1'b0; bus.a_data = '0; bus.b_data = '0; bus.c_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", bus.a_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b expected 0", bus.c_valid); end
    checks++; if (bus.c_row !== '0) begin errors++; $display("FAIL reset_c_row: got %h expected 0", bus.c_row); end
    checks++; if (bus.c_row_idx !== '0) begin errors++; $display("FAIL reset_c_row_idx: got %0d expected 0", bus.c_row_idx); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int exp_row0 [N];
    exp_row0 = '{70, 80, 90, 100};
    fill_ref_pattern();
    do_job(4, 1'b1, 0, -1, 1'b0);
    checks++; if (timeout_o !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timeout_o); end
    for (int j = 0; j < N; j++) begin
      checks++; if (got[0][j] !== CW'(exp_row0[j])) begin errors++; $display("FAIL basic_row0[%0d]: got %0d expected %0d", j, got[0][j], exp_row0[j]); end
    end
    checks++; if (got[3][3] !== 32'd214) begin errors++; $display("FAIL basic_c33: got %0d expected 214", got[3][3]); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++; if (got[r][j] !== ref_c(r, j, 4, 1'b1)) begin errors++; $display("FAIL basic_c[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], ref_c(r, j, 4, 1'b1)); end
      end
    checks++; if (first_cv_cyc !== last_acc_cyc + 2 * N) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first_cv_cyc, last_acc_cyc + 2 * N); end
    checks++; if (order_bad !== 0) begin errors++; $display("FAIL basic_row_order: got %0d expected 0", order_bad); end
    checks++; if (aready_extra !== 0) begin errors++; $display("FAIL basic_a_ready_after_load: got %0d expected 0", aready_extra); end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done_now); end
    checks++; if (cv_after !== 1'b0) begin errors++; $display("FAIL basic_c_valid_after: got %b expected 0", cv_after); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
    checks++; if (done_next !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done_next); end
    checks++; if (done_early !== 0) begin errors++; $display("FAIL basic_done_early: got %0d expected 0", done_early); end
  endtask

  task automatic test_bubbles();
    fill_ref_pattern();
    do_job(4, 1'b0, 1, -1, 1'b0);
    checks++; if (timeout_o !== 0) begin errors++; $display("FAIL bubbles_timeout: got %0d expected 0", timeout_o); end
    checks++; if (got[0][0] !== 32'd70 || got[0][3] !== 32'd100) begin errors++; $display("FAIL bubbles_row0: got %0d,%0d expected 70,100", got[0][0], got[0][3]); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++; if (got[r][j] !== ref_c(r, j, 4, 1'b0)) begin errors++; $display("FAIL bubbles_c[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], ref_c(r, j, 4, 1'b0)); end
      end
    checks++; if (first_cv_cyc !== last_acc_cyc + 2 * N) begin errors++; $display("FAIL bubbles_latency: got %0d expected %0d", first_cv_cyc, last_acc_cyc + 2 * N); end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL bubbles_done: got %b expected 1", done_now); end
  endtask

  task automatic test_signedness();
    logic [CW-1:0] expv [3];
    int kk [3];
    bit sm [3];
    expv = '{32'hFFFF_FFFC, 32'd1020, 32'd16};
    kk   = '{4, 4, 8};
    sm   = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 16; k++) begin
          a_m[i][k] = (t < 2) ? 8'hFF : 8'd1;
          b_m[k][i] = (t < 2) ? 8'h01 : 8'd2;
        end
      do_job(kk[t], sm[t], 0, -1, 1'b0);
      checks++; if (timeout_o !== 0) begin errors++; $display("FAIL sign%0d_timeout: got %0d expected 0", t, timeout_o); end
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          checks++; if (got[r][j] !== expv[t]) begin errors++; $display("FAIL sign%0d_c[%0d][%0d]: got %h expected %h", t, r, j, got[r][j], expv[t]); end
        end
    end
  endtask

  task automatic test_backpressure();
    fill_ref_pattern();
    do_job(4, 1'b1, 0, 1, 1'b1);
    checks++; if (timeout_o !== 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timeout_o); end
    checks++; if (stall_seen !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL bp_row_held: got %0d expected 0", held_bad); end
    checks++; if (order_bad !== 0) begin errors++; $display("FAIL bp_row_order: got %0d expected 0", order_bad); end
    checks++; if (done_early !== 0) begin errors++; $display("FAIL bp_done_early: got %0d expected 0", done_early); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++; if (got[r][j] !== ref_c(r, j, 4, 1'b1)) begin errors++; $display("FAIL bp_c[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], ref_c(r, j, 4, 1'b1)); end
      end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done_now); end
    checks++; if (busy_next !== 1'b0) begin errors++; $display("FAIL bp_start_in_drain_ignored: got busy %b expected 0", busy_next); end
  endtask

  task automatic test_zero_len();
    do_job(0, 1'b1, 0, -1, 1'b0);
    checks++; if (timeout_o !== 0) begin errors++; $display("FAIL zero_timeout: got %0d expected 0", timeout_o); end
    checks++; if (aready_cnt + aready_extra !== 0) begin errors++; $display("FAIL zero_a_ready: got %0d cycles expected 0", aready_cnt + aready_extra); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++; if (got[r][j] !== '0) begin errors++; $display("FAIL zero_c[%0d][%0d]: got %0d expected 0", r, j, got[r][j]); end
      end
    checks++; if (order_bad !== 0) begin errors++; $display("FAIL zero_row_order: got %0d expected 0", order_bad); end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done_now); end
  endtask

  task automatic test_reset_mid_load();
    fill_ref_pattern();
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(6); bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.a_valid = 1'b1; bus.a_data = pack_a(k); bus.b_data = pack_b(k);
      @(negedge clk);
    end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_load: got a_ready %b expected 1", bus.a_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_a_ready: got %b expected 0", bus.a_ready); end
    checks++; if (bus.c_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_c_valid: got %b expected 0", bus.c_valid); end
    bus.a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_job(4, 1'b1, 0, -1, 1'b0);
    checks++; if (timeout_o !== 0) begin errors++; $display("FAIL rst_job_timeout: got %0d expected 0", timeout_o); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++; if (got[r][j] !== ref_c(r, j, 4, 1'b1)) begin errors++; $display("FAIL rst_job_c[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], ref_c(r, j, 4, 1'b1)); end
      end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL rst_job_done: got %b expected 1", done_now); end
  endtask

  task automatic test_random();
    int k;
    bit sm;
    for (int t = 0; t < 8; t++) begin
      k  = $urandom_range(1, 12);
      sm = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < 16; kk++) begin
          a_m[i][kk] = DW'($urandom);
          b_m[kk][i] = DW'($urandom);
        end
      do_job(k, sm, 2, $urandom_range(0, N - 1), 1'b0);
      checks++; if (timeout_o !== 0) begin errors++; $display("FAIL rand%0d_timeout: got %0d expected 0", t, timeout_o); end
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) begin
          checks++; if (got[r][j] !== ref_c(r, j, k, sm)) begin errors++; $display("FAIL rand%0d_c[%0d][%0d]: got %h expected %h (k=%0d sm=%0d)", t, r, j, got[r][j], ref_c(r, j, k, sm), k, sm); end
        end
      checks++; if (first_cv_cyc !== last_acc_cyc + 2 * N) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, first_cv_cyc, last_acc_cyc + 2 * N); end
      checks++; if (held_bad !== 0) begin errors++; $display("FAIL rand%0d_row_held: got %0d expected 0", t, held_bad); end
      checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %b expected 1", t, done_now); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_bubbles();
    test_signedness();
    test_backpressure();
    test_zero_len();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 Parameters: N=4, array dimension; DW=8, operand width; CW=32, accumulator width; KW=16, width of the reduction-length count.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  begin job when sampled high in IDLE.
REQ-005 k_len  in  KW  reduction depth K, sampled with start.
REQ-006 signed_mode  in  1  1=signed operands, 0=unsigned, sampled with start.
REQ-007 a_valid  in  1  beat valid for a_data and b_data.
REQ-008 a_ready  out  1  beat accepted when a_valid&&a_ready.
REQ-009 a_data  in  N*DW  column k of A, lane i = A[i][k].
REQ-010 b_data  in  N*DW  row k of B, lane j = B[k][j].
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 c_valid  out  1  c_row holds a result row.
REQ-013 c_ready  in  1  consumer accepts row when c_valid&&c_ready.
REQ-014 c_row  out  N*CW  row r of C, lane j = C[r][j].
REQ-015 c_row_idx  out  $clog2(N)  index r of the presented row.
REQ-016 done  out  1  one-cycle pulse after the last row handshake.

Function
REQ-017 States: IDLE, LOAD, FLUSH, DRAIN, in that order.
REQ-018 IDLE->LOAD on start with k_len>0; IDLE->DRAIN on start with k_len=0; start outside IDLE is ignored.
REQ-019 Accepting start clears all N*N accumulators and latches k_len and signed_mode.
REQ-020 a_ready=1 only in LOAD; LOAD->FLUSH on the edge accepting beat k_len.
REQ-021 Internal skew: lane i of A delayed i cycles, lane j of B delayed j cycles; the array shifts every cycle, and a cycle without an accepted beat injects zeros, so bubbles never change results.
REQ-022 PE(i,j) adds a*b to its accumulator each cycle, passes a right and b down with 1-cycle registers.
REQ-023 Arithmetic: 2*DW product, sign-extended (signed_mode=1) or zero-extended (0) to CW, wrap modulo 2^CW.
REQ-024 FLUSH lasts exactly 2N-1 cycles, then DRAIN; c_valid first rises 2N cycles after the last-beat acceptance cycle.
REQ-025 DRAIN presents rows 0..N-1 in order; c_row and c_row_idx stay stable while c_valid&&!c_ready.
REQ-026 On the handshake of row N-1: c_valid=0 and done=1 for one cycle next cycle, state IDLE.
REQ-027 k_len=0 drains N zero rows with no a_ready.

Reset
REQ-028 rst_n low at any time forces IDLE immediately and clears skew registers, accumulators and latched fields.
REQ-029 Reset values: a_ready=0, busy=0, c_valid=0, c_row=0, c_row_idx=0, done=0.

Structure
REQ-030 Package systolic_pkg holds the state enum and the default N/DW/CW/KW constants.
REQ-031 Sub-module systolic_pe (MAC, forward registers, clear, signed_mode) instantiated N*N times via generate.

Verification
REQ-032 A[i][k]=i+k+1, B[k][j]=k+j+5, k_len=4, continuous valid, c_ready=1 -> row0 = 70,80,90,100; C[3][3]=214; done 1 cycle after row 3.
REQ-033 Same job with a_valid toggling every other cycle -> results identical to REQ-032.
REQ-034 k_len=4, all A=0xFF, all B=0x01: signed_mode=1 -> every C=-4; signed_mode=0 -> every C=1020; k_len=8, A=1, B=2 -> every C=16.
REQ-035 c_ready low 3 cycles at row 1 -> c_row_idx=1 and data held, no done until row 3 accepted; start pulsed during DRAIN is ignored.
REQ-036 k_len=0 -> a_ready never high, four zero rows, done pulse.
REQ-037 rst_n low mid-LOAD -> busy, a_ready, c_valid 0 with no clock edge; a following REQ-032 job passes.
